status_reg: RTL and testbench

STATUS_REG -- requirements
Module: status_reg

---
 rtl/status_reg_pkg.sv | 41 ++++
 rtl/status_reg_sync2.sv | 24 ++
 rtl/status_reg.sv | 104 ++++++++++
 tb/tb_status_reg.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/status_reg_pkg.sv
// Shared CPU definitions: status flag bit positions and explicit status-op codes.
// Pure constants and one helper function; no latency.
// No flow control.
package status_reg_pkg;

    // Flag bit positions inside the status byte {N,V,HC,B,D,I,Z,C}
    localparam int FLAG_C  = 0;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_I  = 2;
    localparam int FLAG_D  = 3;
    localparam int FLAG_B  = 4;
    localparam int FLAG_HC = 5;
    localparam int FLAG_V  = 6;
    localparam int FLAG_N  = 7;

    // Explicit status operations; codes 9..15 are treated as NOP
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_CLC = 4'd1;
    localparam logic [3:0] OP_SEC = 4'd2;
    localparam logic [3:0] OP_CLI = 4'd3;
    localparam logic [3:0] OP_SEI = 4'd4;
    localparam logic [3:0] OP_CLD = 4'd5;
    localparam logic [3:0] OP_SED = 4'd6;
    localparam logic [3:0] OP_CLV = 4'd7;
    localparam logic [3:0] OP_PLP = 4'd8;

    // Status value after reset: only the interrupt mask set
    localparam logic [7:0] P_RESET  = 8'h04;
    // Bits owned by the ALU write-back: N,V,HC,Z,C
    localparam logic [7:0] ALU_MASK = 8'hE3;
    // Bits restored by PLP/RTI: N,V,D,I,Z,C (HC and B are kept internal)
    localparam logic [7:0] PLP_MASK = 8'hCF;

    // Replace the bits selected by mask with the corresponding bits of upd
    function automatic logic [7:0] merge_bits(input logic [7:0] cur,
                                              input logic [7:0] upd,
                                              input logic [7:0] mask);
        return (cur & ~mask) | (upd & mask);
    endfunction

endpackage

// File: rtl/status_reg_sync2.sv
// Two-flop synchronizer for an asynchronous active-low input.
// Latency: two clk cycles from input change to q.
// No flow control; resets to the released (high) level.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous input through two flops; reset to released level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/status_reg.sv
// Processor status register with interrupt recognition and branch flag select.
// Latency: p updates one cycle after an op/load; p_push and br_taken are combinational.
// No flow control; every strobe is consumed in the cycle it is presented.
module status_reg
    import status_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] p,
    input  logic [7:0] alu_flags,
    input  logic       p_load,
    input  logic [3:0] p_op,
    input  logic [7:0] data_i,
    input  logic       brk_flag,
    output logic [7:0] p_push,
    input  logic       irq_n,
    input  logic       nmi_n,
    input  logic       nmi_ack,
    output logic       irq_pending,
    output logic       nmi_pending,
    input  logic [1:0] br_sel,
    input  logic       br_val,
    output logic       br_taken
);

    logic [7:0] p_nxt;
    logic       i_dly;
    logic       irq_sync;
    logic       nmi_sync;
    logic       nmi_hist;
    logic       nmi_fall;
    logic       br_flag;

    sync2 u_irq_sync (.clk(clk), .rst(rst), .d(irq_n), .q(irq_sync));
    sync2 u_nmi_sync (.clk(clk), .rst(rst), .d(nmi_n), .q(nmi_sync));

    // Next status: ALU write-back first, then explicit op/PLP override the bits they own
    always_comb begin
        p_nxt = p;
        if (p_load) begin
            p_nxt = merge_bits(p_nxt, alu_flags, ALU_MASK);
        end
        case (p_op)
            OP_CLC:  p_nxt[FLAG_C] = 1'b0;
            OP_SEC:  p_nxt[FLAG_C] = 1'b1;
            OP_CLI:  p_nxt[FLAG_I] = 1'b0;
            OP_SEI:  p_nxt[FLAG_I] = 1'b1;
            OP_CLD:  p_nxt[FLAG_D] = 1'b0;
            OP_SED:  p_nxt[FLAG_D] = 1'b1;
            OP_CLV:  p_nxt[FLAG_V] = 1'b0;
            OP_PLP:  p_nxt = merge_bits(p_nxt, data_i, PLP_MASK);
            default: ;
        endcase
        p_nxt[FLAG_B] = 1'b0;
    end

    // Status register plus the mask copy used for interrupt recognition;
    // i_dly tracks the I value p is about to show, so recognition trails p by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p     <= P_RESET;
            i_dly <= 1'b1;
        end else begin
            p     <= p_nxt;
            i_dly <= p_nxt[FLAG_I];
        end
    end

    assign nmi_fall = nmi_hist & ~nmi_sync;

    // Level IRQ gated by the mask copy; NMI latched on a synchronized falling edge,
    // with a new edge winning over a same-cycle acknowledge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_pending <= 1'b0;
            nmi_pending <= 1'b0;
            nmi_hist    <= 1'b1;
        end else begin
            irq_pending <= ~irq_sync & ~i_dly;
            nmi_hist    <= nmi_sync;
            if (nmi_fall) begin
                nmi_pending <= 1'b1;
            end else if (nmi_ack) begin
                nmi_pending <= 1'b0;
            end
        end
    end

    // Push image always shows bit5 set and B from the pushing sequence
    assign p_push = {p[FLAG_N], p[FLAG_V], 1'b1, brk_flag,
                     p[FLAG_D], p[FLAG_I], p[FLAG_Z], p[FLAG_C]};

    // Branch condition: pick one flag and compare against the wanted value
    always_comb begin
        case (br_sel)
            2'd0:    br_flag = p[FLAG_N];
            2'd1:    br_flag = p[FLAG_V];
            2'd2:    br_flag = p[FLAG_C];
            default: br_flag = p[FLAG_Z];
        endcase
        br_taken = (br_flag == br_val);
    end

endmodule

// File: tb/tb_status_reg.sv
// Randomized and directed bench for status_reg against a flag-level reference model.
// Inputs change on the falling edge; registered outputs are checked on the falling edge.
// No flow control in the design under test.
module tb_status_reg;

    logic       clk;
    logic       rst;
    logic [7:0] p;
    logic [7:0] alu_flags;
    logic       p_load;
    logic [3:0] p_op;
    logic [7:0] data_i;
    logic       brk_flag;
    logic [7:0] p_push;
    logic       irq_n;
    logic       nmi_n;
    logic       nmi_ack;
    logic       irq_pending;
    logic       nmi_pending;
    logic [1:0] br_sel;
    logic       br_val;
    logic       br_taken;

    int checks = 0;
    int errors = 0;

    // Reference model: individual flags and input sample history
    logic m_n, m_v, m_hc, m_d, m_i, m_z, m_c;
    logic m_irqp, m_nmip;
    logic irq_s1, irq_s2;          // irq_n sampled one and two edges ago
    logic nmi_s1, nmi_s2, nmi_s3;  // nmi_n sampled one, two, three edges ago

    status_reg dut (
        .clk(clk), .rst(rst), .p(p), .alu_flags(alu_flags), .p_load(p_load),
        .p_op(p_op), .data_i(data_i), .brk_flag(brk_flag), .p_push(p_push),
        .irq_n(irq_n), .nmi_n(nmi_n), .nmi_ack(nmi_ack),
        .irq_pending(irq_pending), .nmi_pending(nmi_pending),
        .br_sel(br_sel), .br_val(br_val), .br_taken(br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_p();
        return {m_n, m_v, m_hc, 1'b0, m_d, m_i, m_z, m_c};
    endfunction

    function automatic logic [7:0] m_push();
        return {m_n, m_v, 1'b1, brk_flag, m_d, m_i, m_z, m_c};
    endfunction

    function automatic logic m_br();
        logic f;
        case (br_sel)
            2'd0:    f = m_n;
            2'd1:    f = m_v;
            2'd2:    f = m_c;
            default: f = m_z;
        endcase
        return f == br_val;
    endfunction

    task automatic model_reset();
        {m_n, m_v, m_hc, m_d, m_z, m_c} = 6'b0;
        m_i    = 1'b1;
        m_irqp = 1'b0;
        m_nmip = 1'b0;
        {irq_s1, irq_s2}         = 2'b11;
        {nmi_s1, nmi_s2, nmi_s3} = 3'b111;
    endtask

    // Apply one rising edge to the model using the inputs currently driven
    task automatic model_edge();
        logic fall;
        // IRQ seen two edges late, masked by I as it stood before this edge
        m_irqp = !irq_s2 && !m_i;
        // NMI edge after the two-edge synchronizer delay
        fall   = nmi_s3 && !nmi_s2;
        m_nmip = fall || (m_nmip && !nmi_ack);
        irq_s2 = irq_s1; irq_s1 = irq_n;
        nmi_s3 = nmi_s2; nmi_s2 = nmi_s1; nmi_s1 = nmi_n;
        if (p_load) begin
            m_n = alu_flags[7]; m_v = alu_flags[6]; m_hc = alu_flags[5];
            m_z = alu_flags[1]; m_c = alu_flags[0];
        end
        case (p_op)
            4'd1: m_c = 1'b0;
            4'd2: m_c = 1'b1;
            4'd3: m_i = 1'b0;
            4'd4: m_i = 1'b1;
            4'd5: m_d = 1'b0;
            4'd6: m_d = 1'b1;
            4'd7: m_v = 1'b0;
            4'd8: begin
                m_n = data_i[7]; m_v = data_i[6]; m_d = data_i[3];
                m_i = data_i[2]; m_z = data_i[1]; m_c = data_i[0];
            end
            default: ;
        endcase
    endtask

    // One clock cycle: inputs were just set after a falling edge
    task automatic cyc();
        #1;
        chk("p_push", p_push, m_push());
        chk("br_taken", {7'b0, br_taken}, {7'b0, m_br()});
        model_edge();
        @(negedge clk);
        chk("p", p, m_p());
        chk("irq_pending", {7'b0, irq_pending}, {7'b0, m_irqp});
        chk("nmi_pending", {7'b0, nmi_pending}, {7'b0, m_nmip});
    endtask

    task automatic idle();
        p_load = 1'b0; p_op = 4'd0; alu_flags = 8'h00; data_i = 8'h00; nmi_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        brk_flag = 1'b1; irq_n = 1'b1; nmi_n = 1'b1; br_sel = 2'd0; br_val = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset state
        chk("rst_p", p, 8'h04);
        chk("rst_push", p_push, 8'h34);
        chk("rst_irq", {7'b0, irq_pending}, 8'h00);
        chk("rst_nmi", {7'b0, nmi_pending}, 8'h00);
        rst = 1'b0;
        cyc();

        // ALU write-back leaves D, I, B alone
        p_load = 1'b1; alu_flags = 8'hE3; cyc();
        chk("load_e3", p, 8'hE7);

        // Simultaneous load and CLC: op owns C
        alu_flags = 8'h01; p_op = 4'd1; cyc();
        chk("load_clc_c", {7'b0, p[0]}, 8'h00);
        chk("load_clc_z", {7'b0, p[1]}, 8'h00);
        idle(); p_op = 4'd8; data_i = 8'hFF; cyc();
        chk("plp_hc0", p, 8'hCF);
        idle(); p_load = 1'b1; alu_flags = 8'h20; cyc();
        idle(); p_op = 4'd8; data_i = 8'hFF; cyc();
        chk("plp_hc1", p, 8'hEF);

        // IRQ recognition trails CLI/SEI by one cycle past p
        idle(); irq_n = 1'b0;
        repeat (3) cyc();
        chk("irq_masked", {7'b0, irq_pending}, 8'h00);
        p_op = 4'd3; cyc();
        chk("cli_i", {7'b0, p[2]}, 8'h00);
        chk("cli_irq_t1", {7'b0, irq_pending}, 8'h00);
        idle(); cyc();
        chk("cli_irq_t2", {7'b0, irq_pending}, 8'h01);
        p_op = 4'd4; cyc();
        chk("sei_irq_t1", {7'b0, irq_pending}, 8'h01);
        idle(); cyc();
        chk("sei_irq_t2", {7'b0, irq_pending}, 8'h00);
        irq_n = 1'b1;

        // NMI edge, ack, no retrigger while held low, edge beats ack
        nmi_n = 1'b0; cyc(); cyc();
        chk("nmi_t2", {7'b0, nmi_pending}, 8'h00);
        cyc();
        chk("nmi_t3", {7'b0, nmi_pending}, 8'h01);
        nmi_ack = 1'b1; cyc();
        chk("nmi_ack", {7'b0, nmi_pending}, 8'h00);
        nmi_ack = 1'b0; repeat (3) cyc();
        chk("nmi_held", {7'b0, nmi_pending}, 8'h00);
        nmi_n = 1'b1; repeat (3) cyc();
        nmi_n = 1'b0; cyc(); cyc();
        nmi_ack = 1'b1; cyc();
        chk("nmi_edge_ack", {7'b0, nmi_pending}, 8'h01);
        nmi_ack = 1'b0;

        // Branch select with p = 02
        p_load = 1'b1; alu_flags = 8'h00; cyc();
        idle(); p_op = 4'd8; data_i = 8'h02; cyc();
        chk("p_02", p, 8'h02);
        idle(); br_sel = 2'd3; br_val = 1'b1; #1;
        chk("br_z1", {7'b0, br_taken}, 8'h01);
        br_sel = 2'd2; #1;
        chk("br_c1", {7'b0, br_taken}, 8'h00);
        @(negedge clk);

        // Mid-cycle reset discards pending NMI and in-flight op at once
        nmi_n = 1'b1; repeat (3) cyc();
        nmi_n = 1'b0; repeat (3) cyc();
        chk("nmi_before_rst", {7'b0, nmi_pending}, 8'h01);
        p_op = 4'd6; #2;
        rst = 1'b1; #1;
        chk("rst_async_p", p, 8'h04);
        chk("rst_async_nmi", {7'b0, nmi_pending}, 8'h00);
        @(negedge clk);
        rst = 1'b0; idle(); model_reset();
        cyc();
        chk("post_rst_nmi", {7'b0, nmi_pending}, 8'h00);
        chk("post_rst_p", p, 8'h04);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            p_load    = 1'($urandom_range(0, 1));
            p_op      = 4'($urandom_range(0, 15));
            alu_flags = 8'($urandom);
            data_i    = 8'($urandom);
            brk_flag  = 1'($urandom_range(0, 1));
            br_sel    = 2'($urandom_range(0, 3));
            br_val    = 1'($urandom_range(0, 1));
            nmi_ack   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) irq_n = ~irq_n;
            if ($urandom_range(0, 5) == 0) nmi_n = ~nmi_n;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
